// File: rtl/weight_tile_scheduler.sv
// weight_tile_scheduler: walks the (out tile, in tile) loop nest of a layer,
// programs the weight loader per tile and handshakes each tile with the PE array.
module weight_tile_scheduler #(
    parameter int TN     = 4,
    parameter int TM     = 8,
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] cfg_base_addr,
    input  logic [ADDR_W-1:0] cfg_tile_words,
    input  logic [CNT_W-1:0]  cfg_n_in_tiles,
    input  logic [CNT_W-1:0]  cfg_m_out_tiles,
    output logic              wctl_state,
    output logic [ADDR_W-1:0] wctl_init_addr,
    output logic [ADDR_W-1:0] wctl_amount,
    input  logic              wctl_ready,
    output logic              pe_start,
    input  logic              pe_done,
    output logic              acc_first,
    output logic              acc_last,
    output logic [CNT_W-1:0]  tile_in_idx,
    output logic [CNT_W-1:0]  tile_out_idx,
    output logic              busy,
    output logic              done
);

    // A default tile (TN*TM words) must be addressable
    if (TN * TM >= (1 << ADDR_W)) begin : g_bad_cfg
        $error("TN*TM does not fit in ADDR_W");
    end

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        COMPUTE,
        NEXT,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic                wctl_state_q, wctl_state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   amount_q, amount_d;
    logic                pe_start_q, pe_start_d;
    logic                done_q, done_d;
    logic [CNT_W-1:0]    in_q, in_d;
    logic [CNT_W-1:0]    out_q, out_d;
    logic [CNT_W-1:0]    n_q, n_d;
    logic [CNT_W-1:0]    m_q, m_d;

    logic                in_last;
    logic                out_last;
    logic                tile_act;

    assign in_last  = (in_q == n_q - CNT_W'(1));
    assign out_last = (out_q == m_q - CNT_W'(1));
    assign tile_act = (state_q == LOAD) || (state_q == COMPUTE);

    // Next-state and next-output logic; abort overrides everything
    always_comb begin
        state_d      = state_q;
        wctl_state_d = wctl_state_q;
        addr_d       = addr_q;
        amount_d     = amount_q;
        pe_start_d   = 1'b0;
        done_d       = 1'b0;
        in_d         = in_q;
        out_d        = out_q;
        n_d          = n_q;
        m_d          = m_q;
        if (abort) begin
            state_d      = IDLE;
            wctl_state_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        n_d      = cfg_n_in_tiles;
                        m_d      = cfg_m_out_tiles;
                        amount_d = cfg_tile_words;
                        addr_d   = cfg_base_addr;
                        in_d     = '0;
                        out_d    = '0;
                        if (cfg_n_in_tiles == '0 || cfg_m_out_tiles == '0) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d      = LOAD;
                            wctl_state_d = 1'b1;
                        end
                    end
                end
                LOAD: begin
                    wctl_state_d = 1'b1;
                    if (wctl_ready) begin
                        state_d    = COMPUTE;
                        pe_start_d = 1'b1;
                    end
                end
                COMPUTE: begin
                    if (!pe_start_q && pe_done) begin
                        state_d      = NEXT;
                        wctl_state_d = 1'b0;
                    end
                end
                NEXT: begin
                    addr_d = addr_q + amount_q;
                    if (in_last) begin
                        in_d  = '0;
                        out_d = out_q + CNT_W'(1);
                    end else begin
                        in_d = in_q + CNT_W'(1);
                    end
                    if (in_last && out_last) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d      = LOAD;
                        wctl_state_d = 1'b1;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d      = IDLE;
                    wctl_state_d = 1'b0;
                end
            endcase
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wctl_state_q <= 1'b0;
            addr_q       <= '0;
            amount_q     <= '0;
            pe_start_q   <= 1'b0;
            done_q       <= 1'b0;
            in_q         <= '0;
            out_q        <= '0;
            n_q          <= '0;
            m_q          <= '0;
        end else begin
            state_q      <= state_d;
            wctl_state_q <= wctl_state_d;
            addr_q       <= addr_d;
            amount_q     <= amount_d;
            pe_start_q   <= pe_start_d;
            done_q       <= done_d;
            in_q         <= in_d;
            out_q        <= out_d;
            n_q          <= n_d;
            m_q          <= m_d;
        end
    end

    assign wctl_state     = wctl_state_q;
    assign wctl_init_addr = addr_q;
    assign wctl_amount    = amount_q;
    assign pe_start       = pe_start_q;
    assign done           = done_q;
    assign tile_in_idx    = in_q;
    assign tile_out_idx   = out_q;
    assign acc_first      = tile_act && (in_q == '0);
    assign acc_last       = tile_act && in_last;
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_weight_tile_scheduler.sv
// tb_weight_tile_scheduler: table of layer configs run against a bench-side
// loader/PE responder, expected tiles queued at start and popped on pe_start.
module tb_weight_tile_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, abort;
    logic [9:0] cfg_base_addr, cfg_tile_words;
    logic [5:0] cfg_n_in_tiles, cfg_m_out_tiles;
    logic       wctl_state;
    logic [9:0] wctl_init_addr, wctl_amount;
    logic       wctl_ready;
    logic       pe_start, pe_done;
    logic       acc_first, acc_last;
    logic [5:0] tile_in_idx, tile_out_idx;
    logic       busy, done;

    weight_tile_scheduler dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_base_addr(cfg_base_addr), .cfg_tile_words(cfg_tile_words),
        .cfg_n_in_tiles(cfg_n_in_tiles), .cfg_m_out_tiles(cfg_m_out_tiles),
        .wctl_state(wctl_state), .wctl_init_addr(wctl_init_addr),
        .wctl_amount(wctl_amount), .wctl_ready(wctl_ready),
        .pe_start(pe_start), .pe_done(pe_done),
        .acc_first(acc_first), .acc_last(acc_last),
        .tile_in_idx(tile_in_idx), .tile_out_idx(tile_out_idx),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] base;
        logic [9:0] words;
        int         n;
        int         m;
        int         rdly;
        int         ddly;
        bit         noise;
        bit         poke;
        int         exp_tiles;
        logic [9:0] exp_last;
    } vec_t;

    typedef struct packed {
        logic [9:0] addr;
        logic [5:0] o;
        logic [5:0] i;
        logic       f;
        logic       l;
    } tile_t;

    tile_t sb[$];

    int tests = 0;
    int fails = 0;

    int cyc = 0;
    logic prev_ws = 1'b0;
    int ld_cnt, pd_cnt, rdly, ddly;
    bit noise;
    bit ev_pe, ev_load, ev_next, ev_done;
    int load_cyc, pe_cyc, next_cyc;
    int loads, pes, dones;
    logic [9:0] last_addr;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {26'd0, wctl_state, wctl_init_addr, wctl_amount, pe_start,
                done, acc_first, acc_last, tile_in_idx, tile_out_idx, busy};
    endfunction

    // One cycle: wait for negedge, record events, drive loader/PE responses
    task automatic step();
        @(negedge clk);
        cyc++;
        ev_pe   = pe_start;
        ev_done = done;
        ev_load = wctl_state && !prev_ws;
        ev_next = !wctl_state && prev_ws && busy;
        prev_ws = wctl_state;
        if (!wctl_state) begin
            wctl_ready = 1'b0;
            ld_cnt     = 0;
        end else if (!wctl_ready) begin
            if (ld_cnt >= rdly) wctl_ready = 1'b1;
            ld_cnt++;
        end
        pe_done = 1'b0;
        if (pe_start) begin
            pd_cnt = ddly;
            if (noise) pe_done = 1'b1;
        end else if (pd_cnt > 0) begin
            pd_cnt--;
            if (pd_cnt == 0) pe_done = 1'b1;
        end
    endtask

    task automatic setup(input vec_t v);
        cfg_base_addr   = v.base;
        cfg_tile_words  = v.words;
        cfg_n_in_tiles  = 6'(v.n);
        cfg_m_out_tiles = 6'(v.m);
        rdly = v.rdly;
        ddly = v.ddly;
        noise = v.noise;
        wctl_ready = 1'b0;
        pe_done = 1'b0;
        pd_cnt = 0;
        ld_cnt = 0;
        loads = 0;
        pes = 0;
        dones = 0;
    endtask

    task automatic run_layer(input vec_t v);
        tile_t t, got;
        bit fin;
        int budget;
        setup(v);
        sb.delete();
        for (int o = 0; o < v.m; o++)
            for (int i = 0; i < v.n; i++) begin
                t.addr = 10'(v.base + (o * v.n + i) * v.words);
                t.o = 6'(o);
                t.i = 6'(i);
                t.f = (i == 0);
                t.l = (i == v.n - 1);
                sb.push_back(t);
            end
        start = 1'b1;
        step();
        start = 1'b0;
        if (v.exp_tiles == 0) begin
            chk("zero_done", {wctl_state, done, pe_start}, 3'b010);
        end else begin
            chk("first_load", {wctl_state, done, wctl_init_addr, wctl_amount},
                {2'b10, v.base, v.words});
            load_cyc = cyc;
            loads = 1;
        end
        fin = ev_done;
        budget = 3000;
        while (!fin && budget > 0) begin
            budget--;
            step();
            start = 1'b0;
            if (ev_load) begin
                loads++;
                load_cyc = cyc;
                chk("ws_low_1cyc", 64'(cyc - next_cyc), 64'd1);
            end
            if (ev_pe) begin
                pes++;
                if (sb.size() == 0) begin
                    chk("extra_pe_start", 64'(pes), 64'(v.exp_tiles));
                end else begin
                    got = sb.pop_front();
                    chk("tile", {wctl_init_addr, tile_out_idx, tile_in_idx,
                                 acc_first, acc_last}, got);
                    last_addr = wctl_init_addr;
                end
                chk("ready_lat", 64'(cyc - load_cyc), 64'(v.rdly + 1));
                pe_cyc = cyc;
                if (v.poke && pes == 1) begin
                    start = 1'b1;
                    cfg_base_addr = v.base + 10'd7;
                    cfg_n_in_tiles = 6'd5;
                    cfg_tile_words = 10'd3;
                end
            end
            if (ev_next) begin
                chk("pe_done_lat", 64'(cyc - pe_cyc), 64'(v.ddly + 1));
                next_cyc = cyc;
            end
            if (ev_done) begin
                fin = 1'b1;
                chk("done_after_next", 64'(cyc - next_cyc), 64'd1);
            end
        end
        if (!fin) chk("layer_timeout", 64'd0, 64'd1);
        step();
        chk("idle_after", {busy, done, wctl_state}, 3'b000);
        chk("pe_count", 64'(pes), 64'(v.exp_tiles));
        chk("sb_empty", 64'(sb.size()), 64'd0);
        if (v.exp_tiles > 0) chk("last_addr", 64'(last_addr), 64'(v.exp_last));
    endtask

    vec_t tbl[6];
    vec_t rv;
    int   budget;

    initial begin
        tbl[0] = '{10'd16,   10'd32, 1, 1, 5, 3, 1'b0, 1'b0, 1, 10'd16};
        tbl[1] = '{10'd0,    10'd32, 2, 3, 2, 2, 1'b0, 1'b0, 6, 10'd160};
        tbl[2] = '{10'd5,    10'd32, 0, 4, 0, 1, 1'b0, 1'b0, 0, 10'd0};
        tbl[3] = '{10'd100,  10'd16, 3, 2, 0, 1, 1'b1, 1'b1, 6, 10'd180};
        tbl[4] = '{10'd1000, 10'd32, 2, 1, 1, 4, 1'b0, 1'b0, 2, 10'd8};
        tbl[5] = '{10'd7,    10'd9,  3, 0, 0, 1, 1'b0, 1'b0, 0, 10'd0};

        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        wctl_ready = 1'b0;
        pe_done = 1'b0;
        cfg_base_addr = '0;
        cfg_tile_words = '0;
        cfg_n_in_tiles = '0;
        cfg_m_out_tiles = '0;
        repeat (2) @(negedge clk);
        chk("reset_state", all_outs(), 64'd0);
        rst_n = 1'b1;
        step();

        foreach (tbl[k]) run_layer(tbl[k]);

        // Abort in LOAD of the third tile, then restart from base
        rv = '{10'd0, 10'd32, 2, 2, 1, 2, 1'b0, 1'b0, 4, 10'd96};
        setup(rv);
        start = 1'b1;
        budget = 500;
        while (loads < 3 && budget > 0) begin
            budget--;
            step();
            start = 1'b0;
            if (ev_load) loads++;
        end
        chk("abort_reach_load", 64'(loads), 64'd3);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_state", {wctl_state, busy, done, pe_start, tile_out_idx,
                            tile_in_idx}, {4'b0000, 6'd1, 6'd0});
        dones = 0;
        repeat (4) begin
            step();
            if (ev_done || busy) dones++;
        end
        chk("abort_quiet", 64'(dones), 64'd0);
        run_layer(rv);

        // Asynchronous reset in the middle of COMPUTE
        setup(tbl[4]);
        start = 1'b1;
        budget = 200;
        ev_pe = 1'b0;
        while (!ev_pe && budget > 0) begin
            budget--;
            step();
            start = 1'b0;
        end
        step();
        chk("pre_reset_busy", {busy, wctl_state, pe_start}, 3'b110);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", all_outs(), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        prev_ws = 1'b0;
        step();
        chk("after_reset_idle", all_outs(), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/weight_tile_scheduler.md
# weight_tile_scheduler

Sequences per-tile weight loads for one convolution layer. Walks the (output-channel tile, input-channel tile) loop nest, programs the weight memory controller with a start address and word count per tile, waits until the weight buffer reports ready, then runs a start/done handshake with the PE array for each tile. It sits between the layer-level top controller and the weight memory controller and PE array.

## Interface
- TN, 4, input channels per tile
- TM, 8, output channels per tile
- ADDR_W, 10, weight memory address / amount width
- CNT_W, 6, tile loop counter width
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  layer start pulse; sampled only in IDLE
- abort  in  1  synchronous abort; returns to IDLE from any state
- cfg_base_addr  in  ADDR_W  first weight word of the layer
- cfg_tile_words  in  ADDR_W  words per tile (normally TN*TM)
- cfg_n_in_tiles  in  CNT_W  input-channel tiles
- cfg_m_out_tiles  in  CNT_W  output-channel tiles
- wctl_state  out  1  enable to weight controller; 0 clears its ready flag
- wctl_init_addr  out  ADDR_W  tile start address
- wctl_amount  out  ADDR_W  tile word count (= latched cfg_tile_words)
- wctl_ready  in  1  weight buffer for current tile loaded
- pe_start  out  1  one-cycle tile compute start
- pe_done  in  1  tile compute finished
- acc_first  out  1  current tile is input tile 0 (PE clears partial sums)
- acc_last  out  1  current tile is last input tile (PE writes back)
- tile_in_idx  out  CNT_W  current input tile index
- tile_out_idx  out  CNT_W  current output tile index
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle layer-complete pulse

## Operation
- States: IDLE, LOAD, COMPUTE, NEXT, DONE.
- IDLE: `start` latches all cfg_* and clears the indices. The running address is set to cfg_base_addr. If either tile count is 0, the next state is DONE. Otherwise it is LOAD.
- LOAD: wctl_state=1, with wctl_init_addr and wctl_amount held stable. When wctl_ready=1 is sampled, go to COMPUTE.
- COMPUTE: wctl_state stays 1. pe_start=1 only on the first COMPUTE cycle. pe_done is ignored in that cycle. A later pe_done=1 moves to NEXT.
- NEXT: wctl_state=0 for exactly one cycle, so the loader re-arms.
  - Input index is the inner loop. tile_in_idx increments and wraps to 0 at cfg_n_in_tiles-1, and then tile_out_idx increments.
  - Address increments by cfg_tile_words, modulo 2^ADDR_W. Overflow wraps silently.
  - If the tile just completed was the last in both loops, go to DONE. Otherwise go to LOAD.
- DONE: done=1 for one cycle, then IDLE.
- acc_first = (tile_in_idx==0). acc_last = (tile_in_idx==cfg_n_in_tiles-1). Both are combinational from the indices and are valid in LOAD and COMPUTE.
- abort: highest priority. Next state is IDLE, wctl_state=0, pe_start=0, no done pulse. Indices freeze until the next start.
- start outside IDLE is ignored. cfg_* changes after latching have no effect.
- Address for tile (o,i) = cfg_base_addr + (o*cfg_n_in_tiles + i)*cfg_tile_words mod 2^ADDR_W. It is produced by accumulation, with no multiplier.

## Timing
- Reset: every output is 0, the state is IDLE, and the internal registers are 0.
- All outputs are registered except acc_first, acc_last and busy, which are decoded from registers.
- start sampled at edge 0. At edge 1 the block is in LOAD with wctl_state=1 and wctl_init_addr=base. For a zero-count config, done=1 in cycle 1 instead.
- wctl_ready sampled high at edge k. COMPUTE begins with pe_start=1 during cycle k+1.
- pe_done sampled at edge d. NEXT occupies cycle d+1, with wctl_state=0 and the indices and address updated at edge d+2.
  - Non-last tile: LOAD in cycle d+2.
  - Last tile: DONE (done=1) in cycle d+2, and busy=0 from cycle d+3.
- Per-tile overhead beyond load and compute: 2 cycles (COMPUTE entry plus NEXT).
- wctl_ready must be ignored in COMPUTE, NEXT and DONE.

## Test plan
- Single tile: base=16, words=32, n=1, m=1, wctl_ready 5 cycles after LOAD, pe_done 3 cycles after pe_start.
  - One pe_start with acc_first=acc_last=1 and init_addr=16.
  - done one cycle after NEXT.
- Loop order: base=0, words=32, n=2, m=3.
  - init_addr sequence 0,32,64,96,128,160.
  - (out,in) order (0,0),(0,1),(1,0),(1,1),(2,0),(2,1).
  - acc_first pattern 1,0,1,0,1,0 and acc_last pattern 0,1,0,1,0,1.
  - Exactly 6 pe_start pulses and 1 done.
  - wctl_state low for exactly 1 cycle between tiles.
- Zero counts: n=0, m=4.
  - done one cycle after start, with no LOAD and no pe_start.
- Busy protection: start pulsed mid-COMPUTE and cfg_base_addr changed.
  - Sequence is unaffected and only one done is produced.
- Abort: abort asserted during LOAD of tile 2.
  - Next cycle: IDLE, wctl_state=0, busy=0, no done.
  - A new start then runs cleanly from base.
- Wrap and reset: base=1000, words=32, n=2, m=1.
  - init_addr 1000 then 8.
  - rst_n asserted mid-COMPUTE clears all outputs asynchronously.
